// File: rtl/adder_8421.sv
// Sequential packed-BCD adder: one digit per clock, least-significant digit first.
// The result is the sum mod 10^DIGITS; c holds the last result and ready pulses once.
module adder_8421 #(
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  start,
  output logic [4*DIGITS-1:0]   c,
  output logic                  ready
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_reg, state_next;
  logic [W-1:0]  a_reg, b_reg, sum_reg, c_reg;
  logic          carry_reg, ready_reg;
  logic [IW-1:0] idx_reg;

  logic [4:0]    digit_sum;
  logic [3:0]    digit;
  logic          carry_next;
  logic          last_digit;
  logic [W-1:0]  sum_next;

  // Digit adder: binary sum, then +6 correction when the digit overflows 9.
  always_comb begin
    digit_sum  = {1'b0, a_reg[3:0]} + {1'b0, b_reg[3:0]} + {4'b0000, carry_reg};
    digit      = digit_sum[3:0];
    carry_next = 1'b0;
    if (digit_sum > 5'd9) begin
      digit      = digit_sum[3:0] + 4'd6;
      carry_next = 1'b1;
    end
  end

  assign last_digit = (idx_reg == IW'(DIGITS - 1));
  assign sum_next   = {digit, sum_reg[W-1:4]};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (last_digit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      c_reg     <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      ready_reg <= 1'b0;
    end else begin
      ready_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
          end
        end
        BUSY: begin
          // Operands shift down so the current digit is always in the low nibble.
          a_reg     <= a_reg >> 4;
          b_reg     <= b_reg >> 4;
          carry_reg <= carry_next;
          sum_reg   <= sum_next;
          idx_reg   <= idx_reg + IW'(1);
          if (last_digit) begin
            c_reg     <= sum_next;
            ready_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign c     = c_reg;
  assign ready = ready_reg;

endmodule

// File: tb/tb_adder_8421.sv
// Bench for adder_8421: directed and random BCD additions checked against a
// decimal-arithmetic reference, including busy protection, reset abort and back-to-back.
module tb_adder_8421;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic        start;
  logic [31:0] c;
  logic        ready;

  int checks = 0;
  int passes = 0;
  logic [31:0] exp_c = 32'h0;

  adder_8421 #(.DIGITS(8)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .start(start), .c(c), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  function automatic longint bcd_to_dec(input logic [31:0] v);
    longint r = 0;
    for (int i = 7; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [31:0] dec_to_bcd(input longint v);
    logic [31:0] r = '0;
    longint t = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_sum(input logic [31:0] x, input logic [31:0] y);
    return dec_to_bcd((bcd_to_dec(x) + bcd_to_dec(y)) % 64'd100000000);
  endfunction

  function automatic logic [31:0] rand_bcd();
    logic [31:0] r = '0;
    for (int i = 0; i < 8; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Runs one operation. poke: cycle offset of an extra start while busy (0 = none).
  // hold: keep start high throughout and leave it high in the ready cycle.
  task automatic run_op(input logic [31:0] xa, input logic [31:0] xb,
                        input int poke, input bit hold, input string tag);
    logic [31:0] want;
    want  = ref_sum(xa, xb);
    a     = xa;
    b     = xb;
    start = 1'b1;
    tick();                                   // T0
    start = hold;
    a     = rand_bcd();
    b     = rand_bcd();
    for (int k = 1; k <= 7; k++) begin
      if (k == poke) begin
        start = 1'b1;
        a     = rand_bcd();
        b     = rand_bcd();
      end
      tick();                                 // T0+k
      start = hold;
      check({tag, " busy_ready"}, {31'b0, ready}, 32'h0);
      check({tag, " busy_c_hold"}, c, exp_c);
    end
    tick();                                   // T0+8
    exp_c = want;
    check({tag, " ready"}, {31'b0, ready}, 32'h1);
    check({tag, " c"}, c, want);
    $display("op %s a=%h b=%h c=%h expected=%h", tag, xa, xb, c, want);
    if (!hold) begin
      tick();                                 // T0+9
      check({tag, " ready_drop"}, {31'b0, ready}, 32'h0);
      check({tag, " c_keep"}, c, want);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    a     = 32'h11111111;
    b     = 32'h22222222;
    tick();
    tick();
    check("reset c", c, 32'h0);
    check("reset ready", {31'b0, ready}, 32'h0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    check("idle ready", {31'b0, ready}, 32'h0);

    run_op(32'h00000123, 32'h00000089, 0, 1'b0, "basic");
    run_op(32'h99999999, 32'h00000001, 0, 1'b0, "overflow");
    run_op(32'h00000999, 32'h00000001, 0, 1'b0, "ripple");
    run_op(32'h00000000, 32'h00000100, 0, 1'b0, "identity");
    run_op(32'h00000100, 32'h00000099, 0, 1'b0, "score");
    run_op(32'h12345678, 32'h87654321, 3, 1'b0, "busy_poke");

    // Reset mid-operation: aborts with no ready pulse and clears c.
    a     = 32'h00004567;
    b     = 32'h00001111;
    start = 1'b1;
    tick();                                   // T0
    start = 1'b0;
    for (int k = 1; k <= 3; k++) tick();
    rst = 1'b1;
    tick();                                   // T0+4
    rst = 1'b0;
    check("abort c", c, 32'h0);
    check("abort ready", {31'b0, ready}, 32'h0);
    exp_c = 32'h0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("abort no_ready", {31'b0, ready}, 32'h0);
      check("abort c_zero", c, 32'h0);
    end
    run_op(32'h00000500, 32'h00000505, 0, 1'b0, "after_abort");

    // Back-to-back with start held high across the ready cycle.
    run_op(32'h00000001, 32'h00000002, 0, 1'b1, "b2b_first");
    run_op(32'h00005555, 32'h00004445, 0, 1'b0, "b2b_second");

    for (int n = 0; n < 20; n++) begin
      logic [31:0] ra, rb;
      ra = rand_bcd();
      rb = rand_bcd();
      run_op(ra, rb, (n % 4 == 1) ? int'($urandom_range(1, 7)) : 0, (n % 5 == 2), "random");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
